vend_sequencer: RTL and testbench

Front-end controller for the coin-operated vending datapath (5/10 coin values, 20-unit price, 5-unit change).
- Arbitrates two coin entry slots (front A, side B) into one credit accumulator.
- Sequences the dispense motor handshake.
- Pays change or refunds through a single-nickel hopper handshake.
- Sits between the coin acceptors and the motor/hopper drivers.

---
 rtl/vend_pkg.sv | 31 +++
 rtl/coin_rr_arb.sv | 28 ++
 rtl/vend_sequencer.sv | 132 +++++++++++++
 tb/tb_vend_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending front-end controller:
// coin encodings, FSM states and the coin-to-nickel conversion.
package vend_pkg;

  localparam int PRICE_N_DEF  = 4;
  localparam int CREDIT_W_DEF = 4;
  localparam int TIMEOUT_DEF  = 15;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_BAD  = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    PAYOUT  = 2'd2
  } state_e;

  // Empty and invalid codes are still consumed by the acceptor; they are worth nothing.
  function automatic logic [1:0] coin_value(input coin_e c);
    case (c)
      COIN_5:  return 2'd1;
      COIN_10: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_rr_arb.sv
// Two-requester round-robin arbiter for the coin slots (bit 0 = A, bit 1 = B).
// The priority pointer only moves when a grant is actually issued.
module coin_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);

  logic prio_b;

  always_comb begin
    // NOTE: default assignment first so no path leaves grant unassigned (no inferred latch).
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) grant = prio_b ? 2'b10 : 2'b01;
      else                grant = valid;
    end
  end

  // Granting A hands priority to B and vice versa.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              prio_b <= 1'b0;
    else if (grant != 2'b00) prio_b <= grant[0];
  end

endmodule

// File: rtl/vend_sequencer.sv
// Coin-slot arbitration, credit accounting, dispense-motor handshake and
// nickel-by-nickel change/refund payout for the vending datapath.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE_N  = PRICE_N_DEF,
  parameter int CREDIT_W = CREDIT_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          a_coin,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [1:0]          b_coin,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic                refund_req,
  output logic                vend_req,
  input  logic                vend_done,
  output logic                hop_pulse,
  input  logic                hop_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                fault
);

  localparam int                  TCNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CREDIT_W-1:0] PRICE        = CREDIT_W'(PRICE_N);
  localparam logic [CREDIT_W-1:0] ONE_NICKEL   = CREDIT_W'(1);
  localparam logic [TCNT_W-1:0]   TIMEOUT_LAST = TCNT_W'(TIMEOUT - 1);

  state_e              state;
  logic [TCNT_W-1:0]   tcnt;
  logic [1:0]          grant;
  logic                coin_en;
  logic [1:0]          sel_coin;
  logic [CREDIT_W-1:0] coin_add;
  logic [CREDIT_W-1:0] sum;

  // A pending refund with credit blocks coin intake; rst_n gating keeps readies low in reset.
  assign coin_en = rst_n && (state == COLLECT) && (!refund_req || credit == '0);

  coin_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid ({b_valid, a_valid}),
    .en    (coin_en),
    .grant (grant)
  );

  assign a_ready  = grant[0];
  assign b_ready  = grant[1];
  assign sel_coin = grant[1] ? b_coin : a_coin;
  assign coin_add = CREDIT_W'(coin_value(coin_e'(sel_coin)));
  assign sum      = credit + coin_add;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      credit    <= '0;
      tcnt      <= '0;
      fault     <= 1'b0;
      vend_req  <= 1'b0;
      hop_pulse <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        COLLECT: begin
          if (refund_req && credit != '0) begin
            state <= PAYOUT;
            busy  <= 1'b1;
          end else if (grant != 2'b00) begin
            if (sum >= PRICE) begin
              state    <= VEND;
              busy     <= 1'b1;
              vend_req <= 1'b1;
              tcnt     <= '0;
              credit   <= sum - PRICE;
            end else begin
              credit <= sum;
            end
          end
        end

        VEND: begin
          if (vend_done) begin
            vend_req <= 1'b0;
            if (credit != '0) state <= PAYOUT;
            else begin
              state <= COLLECT;
              busy  <= 1'b0;
            end
          end else if (tcnt == TIMEOUT_LAST) begin
            // Motor never answered: give the price back and refund everything.
            vend_req <= 1'b0;
            fault    <= 1'b1;
            credit   <= credit + PRICE;
            state    <= PAYOUT;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end

        PAYOUT: begin
          if (hop_pulse) begin
            if (hop_ack) begin
              hop_pulse <= 1'b0;
              credit    <= credit - ONE_NICKEL;
              if (credit == ONE_NICKEL) begin
                state <= COLLECT;
                busy  <= 1'b0;
              end
            end
          end else if (credit != '0) begin
            hop_pulse <= 1'b1;
          end else begin
            state <= COLLECT;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= COLLECT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: a vector table for the coin/vend
// flows plus hand-written sequences for arbitration, refund, timeout and reset.
module tb_vend_sequencer;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] a_coin = 2'b00, b_coin = 2'b00;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, b_ready;
  logic       refund_req = 1'b0;
  logic       vend_req;
  logic       vend_done = 1'b0;
  logic       hop_pulse;
  logic       hop_ack = 1'b0;
  logic [3:0] credit;
  logic       busy, fault;

  always #5 clk = ~clk;

  vend_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_coin     (a_coin),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .b_coin     (b_coin),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .refund_req (refund_req),
    .vend_req   (vend_req),
    .vend_done  (vend_done),
    .hop_pulse  (hop_pulse),
    .hop_ack    (hop_ack),
    .credit     (credit),
    .busy       (busy),
    .fault      (fault)
  );

  int checks = 0;
  int errors = 0;

  typedef enum {OP_COIN, OP_DONE, OP_PAY} op_e;
  typedef struct {
    op_e        op;
    logic       slot;
    logic [1:0] code;
    logic [3:0] exp_credit;
    logic       exp_busy;
    int         n;
  } row_t;
  typedef struct {
    logic [3:0] credit;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  row_t vec[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] c, input logic b);
    exp_t e;
    e.credit = c;
    e.busy   = b;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_credit"}, credit, e.credit);
      check({tag, "_busy"}, busy, e.busy);
    end
  endtask

  task automatic coin(input logic slot, input logic [1:0] code, input logic [3:0] ec,
                      input logic eb, input string tag);
    if (slot) begin b_valid = 1'b1; b_coin = code; end
    else      begin a_valid = 1'b1; a_coin = code; end
    #1;
    check({tag, "_ready"}, slot ? b_ready : a_ready, 1);
    check({tag, "_other_ready"}, slot ? a_ready : b_ready, 0);
    push_exp(ec, eb);
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
    pop_check(tag);
  endtask

  task automatic vend_finish(input logic [3:0] ec, input logic eb, input string tag);
    check({tag, "_vend_req"}, vend_req, 1);
    check({tag, "_no_hop"}, hop_pulse, 0);
    push_exp(ec, eb);
    step();
    step();
    check({tag, "_vend_held"}, vend_req, 1);
    vend_done = 1'b1;
    step();
    vend_done = 1'b0;
    check({tag, "_vend_drop"}, vend_req, 0);
    pop_check(tag);
  endtask

  task automatic pay(input int n, input logic [3:0] ec, input logic eb, input string tag);
    push_exp(ec, eb);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!hop_pulse && w < 10) begin
        step();
        w++;
      end
      check({tag, "_hop_up"}, hop_pulse, 1);
      check({tag, "_hop_credit"}, credit, n - i);
      hop_ack = 1'b1;
      step();
      hop_ack = 1'b0;
      check({tag, "_hop_gap"}, hop_pulse, 0);
    end
    pop_check(tag);
    step();
    step();
    check({tag, "_no_extra_hop"}, hop_pulse, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vec[0]  = '{OP_COIN, 1'b0, 2'b01, 4'd1, 1'b0, 0};
    vec[1]  = '{OP_COIN, 1'b0, 2'b10, 4'd3, 1'b0, 0};
    vec[2]  = '{OP_COIN, 1'b0, 2'b01, 4'd0, 1'b1, 0};
    vec[3]  = '{OP_DONE, 1'b0, 2'b00, 4'd0, 1'b0, 0};
    vec[4]  = '{OP_COIN, 1'b0, 2'b11, 4'd0, 1'b0, 0};
    vec[5]  = '{OP_COIN, 1'b1, 2'b00, 4'd0, 1'b0, 0};
    vec[6]  = '{OP_COIN, 1'b1, 2'b10, 4'd2, 1'b0, 0};
    vec[7]  = '{OP_COIN, 1'b1, 2'b10, 4'd0, 1'b1, 0};
    vec[8]  = '{OP_DONE, 1'b0, 2'b00, 4'd0, 1'b0, 0};
    vec[9]  = '{OP_COIN, 1'b1, 2'b01, 4'd1, 1'b0, 0};
    vec[10] = '{OP_COIN, 1'b1, 2'b10, 4'd3, 1'b0, 0};
    vec[11] = '{OP_COIN, 1'b1, 2'b10, 4'd1, 1'b1, 0};
    vec[12] = '{OP_DONE, 1'b0, 2'b00, 4'd1, 1'b1, 0};
    vec[13] = '{OP_PAY,  1'b0, 2'b00, 4'd0, 1'b0, 1};

    // Reset state, with a coin offered during reset.
    a_valid = 1'b1;
    a_coin  = 2'b01;
    #3;
    check("rst_a_ready", a_ready, 0);
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_vend_req", vend_req, 0);
    check("rst_hop_pulse", hop_pulse, 0);
    a_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      case (vec[i].op)
        OP_COIN: coin(vec[i].slot, vec[i].code, vec[i].exp_credit, vec[i].exp_busy,
                      $sformatf("row%0d", i));
        OP_DONE: vend_finish(vec[i].exp_credit, vec[i].exp_busy, $sformatf("row%0d", i));
        default: pay(vec[i].n, vec[i].exp_credit, vec[i].exp_busy, $sformatf("row%0d", i));
      endcase
    end

    // Both slots valid: grants alternate A, B, A; held slot waits through VEND.
    a_valid = 1'b1; a_coin = 2'b10;
    b_valid = 1'b1; b_coin = 2'b10;
    #1;
    check("rr1_a_ready", a_ready, 1);
    check("rr1_b_ready", b_ready, 0);
    step();
    check("rr1_credit", credit, 2);
    check("rr2_a_ready", a_ready, 0);
    check("rr2_b_ready", b_ready, 1);
    step();
    check("rr2_busy", busy, 1);
    check("rr2_credit", credit, 0);
    check("rr2_vend_req", vend_req, 1);
    for (int i = 0; i < 3; i++) begin
      check("rr_vend_readies", {a_ready, b_ready}, 2'b00);
      step();
    end
    vend_done = 1'b1;
    step();
    vend_done = 1'b0;
    check("rr_back_collect", busy, 0);
    check("rr3_a_ready", a_ready, 1);
    check("rr3_b_ready", b_ready, 0);
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("rr3_credit", credit, 2);

    // Refund with a coin offered on the same cycle.
    coin(1'b0, 2'b01, 4'd3, 1'b0, "pre_refund");
    refund_req = 1'b1;
    a_valid = 1'b1; a_coin = 2'b01;
    #1;
    check("refund_a_ready", a_ready, 0);
    step();
    refund_req = 1'b0;
    check("refund_busy", busy, 1);
    check("refund_credit", credit, 3);
    check("refund_hop_low", hop_pulse, 0);
    hop_ack = 1'b1;
    step();
    hop_ack = 1'b0;
    check("stray_ack_credit", credit, 3);
    check("payout_no_coin", a_ready, 0);
    a_valid = 1'b0;
    pay(3, 4'd0, 1'b0, "refund_pay");
    coin(1'b0, 2'b01, 4'd1, 1'b0, "post_refund");

    // Vend timeout: fault, price restored, full refund.
    coin(1'b0, 2'b01, 4'd2, 1'b0, "to_c1");
    coin(1'b0, 2'b10, 4'd0, 1'b1, "to_c2");
    n = 0;
    while (vend_req && n < 40) begin
      n++;
      step();
    end
    check("to_vend_cycles", n, 15);
    check("to_fault", fault, 1);
    check("to_credit", credit, 4);
    check("to_busy", busy, 1);
    pay(4, 4'd0, 1'b0, "to_pay");
    check("to_fault_sticky", fault, 1);

    // Asynchronous reset mid-VEND.
    coin(1'b0, 2'b10, 4'd2, 1'b0, "rv_c1");
    coin(1'b0, 2'b10, 4'd0, 1'b1, "rv_c2");
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rv_vend_req", vend_req, 0);
    check("rv_busy", busy, 0);
    check("rv_credit", credit, 0);
    check("rv_fault", fault, 0);
    rst_n = 1'b1;
    step();

    // Asynchronous reset mid-PAYOUT, then A priority restored.
    coin(1'b0, 2'b01, 4'd1, 1'b0, "rp_c1");
    refund_req = 1'b1;
    step();
    refund_req = 1'b0;
    check("rp_busy", busy, 1);
    step();
    check("rp_hop_up", hop_pulse, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rp_hop_pulse", hop_pulse, 0);
    check("rp_credit", credit, 0);
    check("rp_busy_rst", busy, 0);
    rst_n = 1'b1;
    step();
    a_valid = 1'b1; a_coin = 2'b01;
    b_valid = 1'b1; b_coin = 2'b01;
    #1;
    check("post_rst_a_ready", a_ready, 1);
    check("post_rst_b_ready", b_ready, 0);
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("post_rst_credit", credit, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
